// File: rtl/sha256_nonce_scheduler.sv
// Drives one shared SHA-256 core through midstate + per-nonce double hash.
// Optional target comparator (hit / hit_nonce) built when TARGET_CMP_EN is defined.
module sha256_nonce_scheduler #(
    parameter int unsigned NUM_NONCES = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [607:0] header,
    input  logic [31:0]  nonce_base,
`ifdef TARGET_CMP_EN
    input  logic [31:0]  target,
    output logic         hit,
    output logic [31:0]  hit_nonce,
`endif
    output logic         busy,
    output logic         result_valid,
    output logic [31:0]  result_nonce,
    output logic [31:0]  result_h0,
    output logic         done,
    output logic         core_start,
    output logic [511:0] core_msg,
    output logic [255:0] core_g,
    input  logic         core_done,
    input  logic [255:0] core_h
);

    localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                   32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    typedef enum logic [2:0] {
        ST_IDLE, ST_MID_GO, ST_MID_WAIT, ST_B2_GO, ST_B2_WAIT, ST_H2_GO, ST_H2_WAIT, ST_DONE
    } state_t;

    state_t             state, state_nx;
    logic [95:0]        hdr_q;
    logic [31:0]        base_q;
    logic [CNT_W-1:0]   cnt;
    logic [255:0]       midstate;
    logic               last;
    logic [31:0]        nonce_cur;

    assign last      = (cnt == CNT_W'(NUM_NONCES - 1));
    assign nonce_cur = base_q + 32'(cnt);

    function automatic logic [511:0] b2_msg(input logic [95:0] w16_18, input logic [31:0] nonce);
        return {32'h00000280, 320'h0, 32'h80000000, nonce, w16_18};
    endfunction

    function automatic logic [511:0] h2_msg(input logic [255:0] d);
        return {32'h00000100, 192'h0, 32'h80000000, d};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (start) state_nx = ST_MID_GO;
            ST_MID_GO:   state_nx = ST_MID_WAIT;
            ST_MID_WAIT: if (core_done) state_nx = ST_B2_GO;
            ST_B2_GO:    state_nx = ST_B2_WAIT;
            ST_B2_WAIT:  if (core_done) state_nx = ST_H2_GO;
            ST_H2_GO:    state_nx = ST_H2_WAIT;
            ST_H2_WAIT:  if (core_done) state_nx = last ? ST_DONE : ST_B2_GO;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        core_start = (state == ST_MID_GO) || (state == ST_B2_GO) || (state == ST_H2_GO);
    end

    // Core operands are loaded on the edge that enters each *_GO state, so they are
    // already valid in the core_start cycle and hold until the matching core_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q        <= '0;
            base_q       <= '0;
            cnt          <= '0;
            midstate     <= '0;
            core_msg     <= '0;
            core_g       <= '0;
            result_valid <= 1'b0;
            result_nonce <= '0;
            result_h0    <= '0;
            done         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= (state == ST_DONE);
            case (state)
                ST_IDLE: if (start) begin
                    hdr_q    <= header[607:512];
                    base_q   <= nonce_base;
                    cnt      <= '0;
                    core_msg <= header[511:0];
                    core_g   <= IV;
                end
                ST_MID_WAIT: if (core_done) begin
                    midstate <= core_h;
                    core_msg <= b2_msg(hdr_q, base_q);
                    core_g   <= core_h;
                end
                ST_B2_WAIT: if (core_done) begin
                    core_msg <= h2_msg(core_h);
                    core_g   <= IV;
                end
                ST_H2_WAIT: if (core_done) begin
                    result_valid <= 1'b1;
                    result_h0    <= core_h[31:0];
                    result_nonce <= nonce_cur;
                    if (!last) begin
                        cnt      <= cnt + CNT_W'(1);
                        core_msg <= b2_msg(hdr_q, nonce_cur + 32'd1);
                        core_g   <= midstate;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TARGET_CMP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit       <= 1'b0;
            hit_nonce <= '0;
        end else if (state == ST_IDLE && start) begin
            hit       <= 1'b0;
            hit_nonce <= '0;
        end else if (state == ST_H2_WAIT && core_done && !hit && core_h[31:0] < target) begin
            hit       <= 1'b1;
            hit_nonce <= nonce_cur;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Directed bench for sha256_nonce_scheduler with a behavioural SHA-256 core of random latency.
module tb_sha256_nonce_scheduler;

    localparam int NN = 4;
    localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                   32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, start;
    logic [607:0] header;
    logic [31:0]  nonce_base;
    logic         busy, result_valid, done, core_start, core_done;
    logic [31:0]  result_nonce, result_h0;
    logic [511:0] core_msg;
    logic [255:0] core_g, core_h;
`ifdef TARGET_CMP_EN
    logic [31:0]  target;
    logic         hit;
    logic [31:0]  hit_nonce;
`endif

    int checks = 0;
    int fails  = 0;

    sha256_nonce_scheduler #(.NUM_NONCES(NN), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .header(header), .nonce_base(nonce_base),
`ifdef TARGET_CMP_EN
        .target(target), .hit(hit), .hit_nonce(hit_nonce),
`endif
        .busy(busy), .result_valid(result_valid), .result_nonce(result_nonce),
        .result_h0(result_h0), .done(done), .core_start(core_start), .core_msg(core_msg),
        .core_g(core_g), .core_done(core_done), .core_h(core_h));

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] g, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, gg, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        a = g[31:0];    b = g[63:32];   c = g[95:64];   d = g[127:96];
        e = g[159:128]; f = g[191:160]; gg = g[223:192]; h = g[255:224];
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & gg)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = gg; gg = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {g[255:224] + h, g[223:192] + gg, g[191:160] + f, g[159:128] + e,
                g[127:96] + d, g[95:64] + c, g[63:32] + b, g[31:0] + a};
    endfunction

    function automatic logic [255:0] exp_mid();
        return sha_compress(IV, header[511:0]);
    endfunction

    function automatic logic [31:0] exp_h0(input logic [31:0] nonce);
        logic [255:0] d1, d2;
        d1 = sha_compress(exp_mid(), {32'h00000280, 320'h0, 32'h80000000, nonce, header[607:512]});
        d2 = sha_compress(IV, {32'h00000100, 192'h0, 32'h80000000, d1});
        return d2[31:0];
    endfunction

    // Behavioural core: captures operands on start, answers after 50..200 cycles.
    logic [511:0] cm_msg;
    logic [255:0] cm_g;
    logic         cm_busy;
    int           cm_wait;
    int           n_starts = 0;
    int           perturb  = 0;
    logic [511:0] cap_msg [$];
    logic [255:0] cap_g [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cm_busy   <= 1'b0;
            core_done <= 1'b0;
            core_h    <= '0;
            cm_wait   <= 0;
        end else begin
            core_done <= 1'b0;
            if (core_start) begin
                n_starts <= n_starts + 1;
                cap_msg.push_back(core_msg);
                cap_g.push_back(core_g);
            end
            if (cm_busy) begin
                if (core_msg !== cm_msg || core_g !== cm_g) perturb <= perturb + 1;
                if (cm_wait == 0) begin
                    cm_busy   <= 1'b0;
                    core_done <= 1'b1;
                    core_h    <= sha_compress(cm_g, cm_msg);
                end else begin
                    cm_wait <= cm_wait - 1;
                end
            end else if (core_start && !core_done) begin
                cm_busy <= 1'b1;
                cm_msg  <= core_msg;
                cm_g    <= core_g;
                cm_wait <= int'($urandom_range(198, 48));
            end
        end
    end

    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] rv_n [$];
    logic [31:0] rv_h [$];
    int          rv_cyc [$];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (result_valid) begin
            rv_n.push_back(result_nonce);
            rv_h.push_back(result_h0);
            rv_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic run_job(input logic [31:0] base, input bit poke, output int s0, output int r0, output int d0);
        int  since;
        bit  finished;
        s0 = n_starts; r0 = rv_n.size(); d0 = done_cnt;
        since = 0; finished = 1'b0;
        @(negedge clk);
        nonce_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6000 && !finished; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && n_starts == s0 + 2) begin
                since++;
                if (since == 5) start = 1'b1;
            end
            if (done_cnt != d0) finished = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!finished) begin
            fails++;
            $display("FAIL job_timeout base=%08h done_seen=0 required=1", base);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, result_valid, done, core_start} !== 4'b0) begin
            fails++; $display("FAIL reset_ctrl got=%b required=0000", {busy, result_valid, done, core_start});
        end
        checks++;
        if (result_nonce !== 32'h0 || result_h0 !== 32'h0) begin
            fails++; $display("FAIL reset_result got=%08h/%08h required=0/0", result_nonce, result_h0);
        end
        checks++;
        if (core_msg !== 512'h0 || core_g !== 256'h0) begin
            fails++; $display("FAIL reset_core_ops nonzero required=0");
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || core_start !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset busy=%b core_start=%b required=0/0", busy, core_start);
        end
    endtask

    task automatic test_double_hash();
        int s0, r0, d0, k;
        logic [255:0] mid;
        logic [511:0] m;
        logic [255:0] g;
        mid = exp_mid();
        run_job(32'h0, 1'b0, s0, r0, d0);
        checks++;
        if (n_starts - s0 != 2 * NN + 1) begin
            fails++; $display("FAIL core_start_count got=%0d required=%0d", n_starts - s0, 2 * NN + 1);
        end
        checks++;
        if (rv_n.size() - r0 != NN) begin
            fails++; $display("FAIL result_count got=%0d required=%0d", rv_n.size() - r0, NN);
        end else begin
            for (int i = 0; i < NN; i++) begin
                checks++;
                if (rv_n[r0+i] !== 32'(i) || rv_h[r0+i] !== exp_h0(32'(i))) begin
                    fails++;
                    $display("FAIL result_%0d got=%08h/%08h required=%08h/%08h", i, rv_n[r0+i], rv_h[r0+i], i, exp_h0(32'(i)));
                end
            end
            checks++;
            if (done_cnt - d0 != 1 || done_cyc != rv_cyc[r0+NN-1] + 1) begin
                fails++;
                $display("FAIL done_timing pulses=%0d cyc=%0d required=1/%0d", done_cnt - d0, done_cyc, rv_cyc[r0+NN-1] + 1);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL busy_after_done got=%b required=0", busy);
        end
        checks++;
        if (perturb != 0) begin
            fails++; $display("FAIL operand_stability changes=%0d required=0", perturb);
        end
        for (int i = 0; i <= 2 * NN && s0 + i < cap_msg.size(); i++) begin
            m = cap_msg[s0+i];
            g = cap_g[s0+i];
            k = (i - 1) / 2;
            checks++;
            if (i == 0) begin
                if (m !== header[511:0] || g !== IV) begin
                    fails++; $display("FAIL mid_ops run=0 g0=%08h required=6a09e667", g[31:0]);
                end
            end else if (i % 2 == 1) begin
                if (m[127:96] !== 32'(k) || m[159:128] !== 32'h80000000 || m[511:480] !== 32'h00000280 || g !== mid) begin
                    fails++;
                    $display("FAIL b2_ops run=%0d w3=%08h w4=%08h w15=%08h g0=%08h required=%08h/80000000/00000280/%08h",
                             i, m[127:96], m[159:128], m[511:480], g[31:0], k, mid[31:0]);
                end
            end else begin
                if (m[287:256] !== 32'h80000000 || m[511:480] !== 32'h00000100 || g[31:0] !== 32'h6a09e667) begin
                    fails++;
                    $display("FAIL h2_ops run=%0d w8=%08h w15=%08h g0=%08h required=80000000/00000100/6a09e667",
                             i, m[287:256], m[511:480], g[31:0]);
                end
            end
        end
    endtask

    task automatic test_nonce_wrap();
        int s0, r0, d0;
        logic [31:0] exp_n [4];
        exp_n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        run_job(32'hFFFFFFFE, 1'b0, s0, r0, d0);
        checks++;
        if (rv_n.size() - r0 != NN) begin
            fails++; $display("FAIL wrap_count got=%0d required=%0d", rv_n.size() - r0, NN);
        end else begin
            for (int i = 0; i < NN; i++) begin
                checks++;
                if (rv_n[r0+i] !== exp_n[i] || rv_h[r0+i] !== exp_h0(exp_n[i])) begin
                    fails++;
                    $display("FAIL wrap_%0d got=%08h/%08h required=%08h/%08h", i, rv_n[r0+i], rv_h[r0+i], exp_n[i], exp_h0(exp_n[i]));
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int s0, r0, d0;
        run_job(32'h00001000, 1'b1, s0, r0, d0);
        checks++;
        if (rv_n.size() - r0 != NN || n_starts - s0 != 2 * NN + 1 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL start_ignored results=%0d starts=%0d dones=%0d required=%0d/%0d/1",
                     rv_n.size() - r0, n_starts - s0, done_cnt - d0, NN, 2 * NN + 1);
        end
        checks++;
        if (rv_n.size() - r0 == NN && rv_n[r0+NN-1] !== 32'h00001003) begin
            fails++; $display("FAIL start_ignored_last got=%08h required=00001003", rv_n[r0+NN-1]);
        end
    endtask

    task automatic test_reset_mid();
        int s0, r0, d0;
        s0 = n_starts;
        @(negedge clk);
        nonce_base = 32'h00000500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && n_starts < s0 + 3; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, result_valid, done, core_start} !== 4'b0 || result_nonce !== 32'h0 || result_h0 !== 32'h0
            || core_msg !== 512'h0 || core_g !== 256'h0) begin
            fails++;
            $display("FAIL reset_mid_outputs ctrl=%b nonce=%08h h0=%08h required=0", {busy, result_valid, done, core_start},
                     result_nonce, result_h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run_job(32'h00000777, 1'b0, s0, r0, d0);
        checks++;
        if (rv_n.size() - r0 != NN || rv_n[rv_n.size()-1] !== 32'h0000077A || rv_h[rv_h.size()-1] !== exp_h0(32'h0000077A)) begin
            fails++; $display("FAIL restart_after_reset results=%0d required=%0d", rv_n.size() - r0, NN);
        end
    endtask

`ifdef TARGET_CMP_EN
    task automatic test_target_cmp();
        int s0, r0, d0;
        logic exp_hit;
        logic [31:0] exp_hn;
        exp_hit = 1'b0; exp_hn = '0;
        for (int i = 0; i < NN; i++)
            if (!exp_hit && exp_h0(32'h00000040 + 32'(i)) < 32'hFFFFFFFF) begin
                exp_hit = 1'b1; exp_hn = 32'h00000040 + 32'(i);
            end
        target = 32'hFFFFFFFF;
        run_job(32'h00000040, 1'b0, s0, r0, d0);
        checks++;
        if (hit !== exp_hit || hit_nonce !== exp_hn) begin
            fails++; $display("FAIL hit_all got=%b/%08h required=%b/%08h", hit, hit_nonce, exp_hit, exp_hn);
        end
        target = 32'h0;
        run_job(32'h00000080, 1'b0, s0, r0, d0);
        checks++;
        if (hit !== 1'b0 || hit_nonce !== 32'h0) begin
            fails++; $display("FAIL hit_none got=%b/%08h required=0/00000000", hit, hit_nonce);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        nonce_base = '0;
        for (int j = 0; j < 19; j++) header[32*j +: 32] = 32'h01234567 ^ (32'(j) * 32'h11111111);
`ifdef TARGET_CMP_EN
        target = '0;
`endif
        test_reset();
        test_double_hash();
        test_nonce_wrap();
        test_start_ignored();
        test_reset_mid();
`ifdef TARGET_CMP_EN
        test_target_cmp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
